// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter slice.
// Holds the requester id type, FSM states and the lowest-index encoder.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] req_id_t;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    function automatic req_id_t lowest_idx(input logic [NUM_REQ-1:0] v);
        req_id_t id;
        id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) id = req_id_t'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Rotated lowest-index-wins pick: scan starts at ptr and wraps modulo 4.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            ptr,
    output req_id_t            win_id,
    output logic               win_valid
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    req_id_t              w_rot_id;

    // w_rot[k] is req[(ptr+k) mod 4]
    assign w_dbl     = {req, req};
    assign w_rot     = NUM_REQ'(w_dbl >> ptr);
    assign w_rot_id  = lowest_idx(w_rot);
    assign win_id    = w_rot_id + ptr;
    assign win_valid = |req;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered, held grants.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD forced-release logic.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output req_id_t            gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    arb_state_t         r_state;
    arb_state_t         w_state_nx;
    req_id_t            r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    req_id_t            r_gnt_id;
    logic               r_gnt_valid;

    req_id_t            w_win_id;
    logic               w_win_valid;
    logic               w_load;
    logic               w_release;
    logic               w_force;

    rr_pick u_pick (
        .req       (req),
        .ptr       (r_ptr),
        .win_id    (w_win_id),
        .win_valid (w_win_valid)
    );

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_release  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_state_nx = GRANT;
                    w_load     = 1'b1;
                end
            end
            GRANT: begin
                if (!req[r_gnt_id] || w_force) begin
                    w_state_nx = IDLE;
                    w_release  = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_load) begin
                r_gnt       <= NUM_REQ'(1) << w_win_id;
                r_gnt_id    <= w_win_id;
                r_gnt_valid <= 1'b1;
                r_ptr       <= FIXED_PRIO ? req_id_t'(0) : w_win_id + 2'd1;
            end else if (w_release) begin
                r_gnt       <= '0;
                r_gnt_id    <= '0;
                r_gnt_valid <= 1'b0;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [3:0] r_hold;
    logic       r_timeout;

    // evict only when the owner still wants the resource and someone else waits
    assign w_force = (r_state == GRANT) && req[r_gnt_id] &&
                     (r_hold == HOLD_LAST) && |(req & ~r_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (w_load) begin
                r_hold <= '0;
            end else if (r_state == GRANT && r_hold != HOLD_LAST) begin
                r_hold <= r_hold + 4'd1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (MAX_HOLD != 0);
    assign w_force      = 1'b0;
    assign timeout      = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: rotation, release, fixed priority,
// reset mid-grant and (with ARB_TIMEOUT_EN) forced release.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    logic [3:0] f_req;
    logic [3:0] f_gnt;
    logic [1:0] f_gnt_id;
    logic       f_gnt_valid;
    logic       f_timeout;

    int n_chk;
    int n_err;

    rr_arbiter4 #(.FIXED_PRIO(1'b0), .MAX_HOLD(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    rr_arbiter4 #(.FIXED_PRIO(1'b1), .MAX_HOLD(8)) u_fix (
        .clk       (clk),
        .rst       (rst),
        .req       (f_req),
        .gnt       (f_gnt),
        .gnt_id    (f_gnt_id),
        .gnt_valid (f_gnt_valid),
        .timeout   (f_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g,
                              input logic [1:0] id, input logic to);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(g != 4'b0));
        if (g != 4'b0) chk({tag, ".id"}, 32'(gnt_id), 32'(id));
        chk({tag, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        f_req = 4'b0000;
        tick();
        tick();
        expect_out("reset", 4'b0000, 2'd0, 1'b0);
        chk("reset.id0", 32'(gnt_id), 32'd0);
        chk("reset.fix", 32'(f_gnt), 32'd0);

        // rotation with all requesting
        rst = 1'b0;
        req = 4'b1111;
        tick(); expect_out("rr0", 4'b0001, 2'd0, 1'b0);
        req = 4'b1110;
        tick(); expect_out("rel0", 4'b0000, 2'd0, 1'b0);
        tick(); expect_out("rr1", 4'b0010, 2'd1, 1'b0);
        req = 4'b1100;
        tick(); expect_out("rel1", 4'b0000, 2'd0, 1'b0);
        tick(); expect_out("rr2", 4'b0100, 2'd2, 1'b0);
        req = 4'b1000;
        tick(); expect_out("rel2", 4'b0000, 2'd0, 1'b0);
        tick(); expect_out("rr3", 4'b1000, 2'd3, 1'b0);
        req = 4'b0111;
        tick(); expect_out("rel3", 4'b0000, 2'd0, 1'b0);
        tick(); expect_out("wrap0", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        tick(); expect_out("relw", 4'b0000, 2'd0, 1'b0);
        tick(); expect_out("idle0", 4'b0000, 2'd0, 1'b0);

        // lone requester 3, then pointer wraps to 0
        req = 4'b1000;
        tick(); expect_out("lone3", 4'b1000, 2'd3, 1'b0);
        req = 4'b0101;
        tick(); expect_out("rel3b", 4'b0000, 2'd0, 1'b0);
        tick(); expect_out("after3", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        tick(); expect_out("rel0b", 4'b0000, 2'd0, 1'b0);

        // owner 1 holds while requester 2 waits
        req = 4'b0110;
        tick(); expect_out("hold1", 4'b0010, 2'd1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int i = 2; i <= 8; i++) begin
            tick(); expect_out("holdc", 4'b0010, 2'd1, 1'b0);
        end
        tick(); expect_out("evict", 4'b0000, 2'd0, 1'b1);
        tick(); expect_out("next2", 4'b0100, 2'd2, 1'b0);
`else
        for (int i = 2; i <= 20; i++) begin
            tick(); expect_out("holdc", 4'b0010, 2'd1, 1'b0);
        end
        req = 4'b0100;
        tick(); expect_out("rel1h", 4'b0000, 2'd0, 1'b0);
        tick(); expect_out("next2", 4'b0100, 2'd2, 1'b0);
`endif
        req = 4'b0000;
        tick(); expect_out("rel2h", 4'b0000, 2'd0, 1'b0);

        // reset during a grant to requester 2
        req = 4'b0100;
        tick(); expect_out("g2", 4'b0100, 2'd2, 1'b0);
        rst = 1'b1;
        req = 4'b0101;
        tick(); expect_out("rstg", 4'b0000, 2'd0, 1'b0);
        tick(); expect_out("rsth", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick(); expect_out("postrst", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        tick();

        // fixed priority: index 1 always beats index 3
        for (int k = 0; k < 4; k++) begin
            f_req = 4'b1010;
            tick();
            chk("fix.gnt", 32'(f_gnt), 32'h2);
            chk("fix.id", 32'(f_gnt_id), 32'd1);
            chk("fix.valid", 32'(f_gnt_valid), 32'd1);
            f_req = 4'b1000;
            tick();
            chk("fix.rel", 32'(f_gnt), 32'h0);
            chk("fix.to", 32'(f_timeout), 32'd0);
        end
        f_req = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource (a priority-encoded datapath port) among requesters. It uses the same lowest-index-wins ordering as the team's priority encoder, rotated by a round-robin pointer so no requester starves. The grant is registered and held until the owner drops its request. An optional hold-time limit can force an early release.

## Interface
- `FIXED_PRIO`, default 0. When 1, the pointer is frozen at 0 and the arbiter is strict priority with req[0] highest.
- `MAX_HOLD`, default 8. Maximum grant length in cycles. Used only with `ARB_TIMEOUT_EN`. Legal range 2..15.
- `clk`, input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`, input, 1 bit. Synchronous, active-high reset.
- `req`, input, 4 bits. Request lines. A requester holds its bit high for as long as it needs the resource.
- `gnt`, output, 4 bits. One-hot grant, registered.
- `gnt_id`, output, 2 bits. Binary index of the owner, registered. Valid only when `gnt_valid`=1.
- `gnt_valid`, output, 1 bit. High whenever `gnt`≠0.
- `timeout`, output, 1 bit. One-cycle pulse on a forced release. Tied 0 without the macro.

## Operation
- Reset values: `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0, state IDLE, pointer `ptr`=0, hold counter 0.
- FSM states:
  - IDLE. If `req`≠0, pick the winner and go to GRANT. Otherwise stay in IDLE.
  - GRANT. Stay while `req[gnt_id]`=1 (subject to the timeout rule). When `req[gnt_id]`=0, clear the grant and return to IDLE.
- Pick rule: scan indices `ptr`, `ptr`+1, … modulo 4. The first index with a set request bit wins.
- Pointer update: on entering GRANT, `ptr` ← winner+1 modulo 4. Index 3 wraps to 0.
- `FIXED_PRIO`=1: `ptr` stays 0.
- Requests from non-owners during GRANT are ignored. Nothing is queued; arbitration re-samples `req` in IDLE.
- `gnt`, `gnt_id` and `gnt_valid` change together on the same edge and are always mutually consistent.
- Owner drops `req` on the same cycle a new requester rises: the grant still goes through IDLE first. No direct handoff.
- `req`=4'b0000 in IDLE: outputs stay 0 and `ptr` is unchanged.

## Timing
- Grant latency: request high at sampling edge N while in IDLE → `gnt` visible after edge N, i.e. one cycle.
- Release latency: owner's `req` low at edge N → `gnt`=0 after edge N.
- Minimum gap between two grants is one IDLE cycle.
- Back-to-back ownership by the same requester needs at least 1 idle cycle. If another requester is pending, the pointer makes it win.
- Reset asserted mid-grant: outputs clear on the next edge and `ptr` returns to 0. Requests seen during reset are discarded.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A hold counter clears on entering GRANT and increments each GRANT cycle.
  - When the counter reaches `MAX_HOLD`-1 and any other `req` bit is high, the next edge clears the grant, enters IDLE and pulses `timeout` for one cycle.
  - `ptr` was already advanced on grant entry, so the next arbitration skips the evicted owner.
  - If no other request is pending, the counter saturates and the grant continues.
- `ARB_TIMEOUT_EN` undefined: no counter is built, `timeout` is constant 0, and grants last until release.

## Structure
- Package `arb_pkg`:
  - `NUM_REQ`=4.
  - `typedef logic [1:0] req_id_t`.
  - `typedef enum logic {IDLE, GRANT} arb_state_t`.
- Sub-module `rr_pick`: a combinational rotated priority pick.
  - Inputs: `req`, `ptr`.
  - Outputs: `win_id`, `win_valid`.
  - It reuses the lowest-index-wins encoding after rotation.

## Test plan
- Reset, then `req`=4'b1111 → after 1 cycle `gnt`=4'b0001, `gnt_id`=0. Drop `req[0]` → `gnt`=0. Next grant `gnt`=4'b0010 (`gnt_id`=1), then 2, then 3, then wrap to 0.
- `req`=4'b1000 alone → `gnt`=4'b1000, `gnt_id`=3, `ptr`=0. A following `req`=4'b0101 → `gnt_id`=0.
- Owner 1 holds 20 cycles while `req[2]` is high, macro undefined → `gnt` stays 4'b0010 for all 20 cycles and `timeout` stays 0.
- Same stimulus, macro defined, `MAX_HOLD`=8 → `gnt` drops after 8 grant cycles, `timeout`=1 for one cycle, next grant `gnt_id`=2.
- `FIXED_PRIO`=1, `req`=4'b1010 sustained, owner toggles release → `gnt_id`=1 every time and index 3 is never granted.
- `rst` asserted during a grant to requester 2 → next cycle all outputs 0. After release of `rst` with `req`=4'b0101 → `gnt_id`=0.
